// File: rtl/dram_write_sched.sv
// Scratchpad row to DRAM write beat scheduler: one latched row is issued as 1..8 beats.
// Optional perf counters are built when DRAM_WRITE_SCHED_PERF_EN is defined.
module dram_write_sched #(
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int ROW_W           = 512,
    parameter int BEAT_W          = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_id,
    input  logic [DRAM_ADDR_WIDTH-1:0] req_dram_addr,
    input  logic [2:0]                 req_num_request,
    input  logic [ROW_W-1:0]           req_row_data,
    input  logic                       be_stall,
    output logic                       dram_valid,
    output logic                       dram_write,
    input  logic                       dram_ready,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    output logic [BEAT_W-1:0]          dram_wdata,
    output logic [4:0]                 dram_num_bytes,
    output logic                       busy,
    output logic                       done_valid,
    output logic [7:0]                 done_id
`ifdef DRAM_WRITE_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_beats,
    output logic [31:0]                perf_stall_cycles
`endif
);

    localparam int NUM_BEATS = ROW_W / BEAT_W;
    localparam int BYTE_SH   = $clog2(BEAT_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    typedef struct packed {
        logic [7:0]                 id;
        logic [DRAM_ADDR_WIDTH-1:0] addr;
        logic [2:0]                 num;
        logic [ROW_W-1:0]           row;
    } req_t;

    state_t state, state_nxt;
    req_t   cur;
    logic [2:0] beat;
    logic [NUM_BEATS-1:0][BEAT_W-1:0] row_beats;
    logic   req_acc, beat_acc, last_beat;

    assign row_beats = cur.row;
    assign req_acc   = req_valid && req_ready;
    assign beat_acc  = (state == ISSUE) && !be_stall && dram_ready;
    assign last_beat = beat_acc && (beat == cur.num);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_acc)   state_nxt = ISSUE;
            ISSUE:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cur  <= '0;
            beat <= '0;
        end else if (req_acc) begin
            cur  <= '{id: req_id, addr: req_dram_addr, num: req_num_request, row: req_row_data};
            beat <= '0;
        end else if (beat_acc) begin
            beat <= beat + 3'd1;
        end
    end

    // Address and data are zeroed outside ISSUE so idle outputs match the reset image.
    always_comb begin
        req_ready      = 1'b0;
        dram_valid     = 1'b0;
        dram_addr      = '0;
        dram_wdata     = '0;
        busy           = 1'b1;
        done_valid     = 1'b0;
        done_id        = '0;
        dram_num_bytes = 5'(BEAT_W / 8);
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ISSUE: begin
                dram_valid = !be_stall;
                dram_addr  = cur.addr + (DRAM_ADDR_WIDTH'(beat) << BYTE_SH);
                dram_wdata = row_beats[beat];
            end
            DONE: begin
                done_valid = 1'b1;
                done_id    = cur.id;
            end
            default: ;
        endcase
    end

    assign dram_write = dram_valid;

`ifdef DRAM_WRITE_SCHED_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_beats        <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (beat_acc && perf_beats != '1)
                perf_beats <= perf_beats + 32'd1;
            if (state == ISSUE && be_stall && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_write_sched.sv
// Directed bench for dram_write_sched: burst, single beat, stall, wrap, back-pressure, reset.
module tb_dram_write_sched;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_id;
    logic [31:0]  req_dram_addr;
    logic [2:0]   req_num_request;
    logic [511:0] req_row_data;
    logic         be_stall;
    logic         dram_valid;
    logic         dram_write;
    logic         dram_ready;
    logic [31:0]  dram_addr;
    logic [63:0]  dram_wdata;
    logic [4:0]   dram_num_bytes;
    logic         busy;
    logic         done_valid;
    logic [7:0]   done_id;

    int n_tests = 0;
    int n_fail  = 0;

    dram_write_sched dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_dram_addr(req_dram_addr), .req_num_request(req_num_request),
        .req_row_data(req_row_data), .be_stall(be_stall),
        .dram_valid(dram_valid), .dram_write(dram_write), .dram_ready(dram_ready),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_num_bytes(dram_num_bytes),
        .busy(busy), .done_valid(done_valid), .done_id(done_id)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Beat k of the test row is 0x0101..01 * (k+1): beat0 = 0x0101..., beat7 = 0x0808...
    function automatic logic [63:0] beat_val(input int k);
        return 64'h0101_0101_0101_0101 * 64'(k + 1);
    endfunction

    // Called on a negedge; offers one request at cycle 0 and checks each beat and the done pulse.
    task automatic run_req(input logic [7:0] id, input logic [31:0] addr, input logic [2:0] nr,
                           input int stall_beat, input int stall_len, input int exp_done);
        int beat = 0;
        int stalled = 0;
        int cyc = 0;
        logic [31:0] ea;
        req_valid = 1'b1; req_id = id; req_dram_addr = addr; req_num_request = nr;
        #1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        cyc = 1;
        while (beat <= int'(nr) && cyc < 50) begin
            be_stall = (beat == stall_beat) && (stalled < stall_len);
            #1;
            chk("busy_issue", 64'(busy), 64'd1);
            chk("req_ready_issue", 64'(req_ready), 64'd0);
            if (be_stall) begin
                chk("stall_valid", 64'(dram_valid), 64'd0);
                stalled++;
            end else begin
                ea = addr + 32'(beat * 8);
                chk("beat_valid", 64'(dram_valid), 64'd1);
                chk("beat_write", 64'(dram_write), 64'd1);
                chk("beat_addr", 64'(dram_addr), 64'(ea));
                chk("beat_wdata", dram_wdata, beat_val(beat));
                beat++;
            end
            @(negedge CLK);
            cyc++;
        end
        be_stall = 1'b0;
        #1;
        chk("done_cycle", 64'(cyc), 64'(exp_done));
        chk("done_valid", 64'(done_valid), 64'd1);
        chk("done_id", 64'(done_id), 64'(id));
        chk("done_dram_valid", 64'(dram_valid), 64'd0);
        @(negedge CLK);
        #1;
        chk("after_done_valid", 64'(done_valid), 64'd0);
        chk("after_busy", 64'(busy), 64'd0);
        chk("after_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_id = '0; req_dram_addr = '0;
        req_num_request = '0; be_stall = 1'b0; dram_ready = 1'b1;
        for (int k = 0; k < 8; k++) req_row_data[k*64 +: 64] = beat_val(k);
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_dram_valid", 64'(dram_valid), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_dram_valid", 64'(dram_valid), 64'd0);
        chk("rst_dram_write", 64'(dram_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_done_id", 64'(done_id), 64'd0);
        chk("rst_dram_addr", 64'(dram_addr), 64'd0);
        chk("rst_dram_wdata", dram_wdata, 64'd0);
        chk("rst_num_bytes", 64'(dram_num_bytes), 64'd8);

        // 8-beat burst, done at cycle 9
        run_req(8'h11, 32'h0000_1000, 3'd7, -1, 0, 9);
        // single beat, done at cycle 2
        run_req(8'h5A, 32'h0000_0040, 3'd0, -1, 0, 2);
        // 3-cycle stall on beat 2, done at 8 + 3 + 1 = 12
        run_req(8'h77, 32'h0000_2000, 3'd7, 2, 3, 12);
        // address wrap: 0xFFFFFFF8 then 0x00000000
        run_req(8'h99, 32'hFFFF_FFF8, 3'd1, -1, 0, 3);

        // Second request held during ISSUE: A (2 beats) then B accepted in the IDLE cycle after DONE
        req_valid = 1'b1; req_id = 8'h22; req_dram_addr = 32'h0000_3000; req_num_request = 3'd1;
        #1; chk("bp_acc_a", 64'(req_ready), 64'd1);
        @(negedge CLK);
        req_id = 8'h33; req_dram_addr = 32'h0000_4000; req_num_request = 3'd0;
        #1; chk("bp_c1_ready", 64'(req_ready), 64'd0);
        chk("bp_c1_addr", 64'(dram_addr), 64'h3000);
        @(negedge CLK); #1;
        chk("bp_c2_ready", 64'(req_ready), 64'd0);
        chk("bp_c2_addr", 64'(dram_addr), 64'h3008);
        @(negedge CLK); #1;
        chk("bp_c3_ready", 64'(req_ready), 64'd0);
        chk("bp_c3_done_id", 64'(done_id), 64'h22);
        @(negedge CLK); #1;
        chk("bp_c4_ready", 64'(req_ready), 64'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("bp_b_valid", 64'(dram_valid), 64'd1);
        chk("bp_b_addr", 64'(dram_addr), 64'h4000);
        chk("bp_b_wdata", dram_wdata, 64'h0101_0101_0101_0101);
        @(negedge CLK); #1;
        chk("bp_b_done", 64'(done_valid), 64'd1);
        chk("bp_b_done_id", 64'(done_id), 64'h33);
        @(negedge CLK);

        // Reset after beat 3 is accepted: request drops, no completion pulse
        req_valid = 1'b1; req_id = 8'h44; req_dram_addr = 32'h0000_5000; req_num_request = 3'd7;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rs_beat3_addr", 64'(dram_addr), 64'h5018);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_dram_valid", 64'(dram_valid), 64'd0);
        chk("rs_done_valid", 64'(done_valid), 64'd0);
        chk("rs_done_id", 64'(done_id), 64'd0);
        chk("rs_req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); #1;
            chk("rs_no_done", 64'(done_valid), 64'd0);
            chk("rs_idle_valid", 64'(dram_valid), 64'd0);
        end
        run_req(8'h66, 32'h0000_6000, 3'd2, -1, 0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
